hdr_pair_scheduler: RTL
=======================

Name: hdr_pair_scheduler

Overview:
- Sequences the two exposure streams (long/short) into the fixed-latency HDR merge stage.
- The merge stage has no backpressure and a fixed pipeline, so this block does the following:
  - pairs beats from both sources and aligns them on SOP;
  - issues a pair only when a downstream output-FIFO credit is available;
  - resynchronises both streams after a framing mismatch.
- Sits between the frame-buffer readers and the HDR merge stage.

Parameters:
- DATA_WIDTH, 32, pixel word width per stream.
- FIFO_DEPTH, 32, words of downstream FIFO; sets the initial credit count (≥1, ≤ 2^CW−1).
- CW, 6, credit counter width; must satisfy FIFO_DEPTH < 2^CW.
- FCW, 16, frame counter width.

Ports:
- clk  in  1  single clock.
- reset  in  1  asynchronous, active-high reset.
- enable_i  in  1  run enable; sampled at frame boundaries.
- snk0_valid_i / snk0_data_i / snk0_sop_i / snk0_eop_i  in  1/DATA_WIDTH/1/1  exposure 0 stream.
- snk0_ready_o  out  1  exposure 0 accept.
- snk1_valid_i / snk1_data_i / snk1_sop_i / snk1_eop_i  in  1/DATA_WIDTH/1/1  exposure 1 stream.
- snk1_ready_o  out  1  exposure 1 accept.
- fifo_pop_i  in  1  downstream FIFO read; returns one credit.
- hdr_valid_o / hdr_sop_o / hdr_eop_o  out  1/1/1  sideband to merge stage.
- hdr_data0_o / hdr_data1_o  out  DATA_WIDTH each  paired pixels to merge stage.
- sync_err_o  out  1  one-cycle pulse on framing mismatch.
- frame_cnt_o  out  FCW  completed frames; wraps.
- busy_o  out  1  state != IDLE.

Behaviour:
- Reset: state=IDLE, cred=FIFO_DEPTH, frame_cnt=0, all outputs 0 (readys 0, hdr_* 0, sync_err 0).
- Transfer on a sink: valid_i & ready_o in the same cycle.
- fire (pair issue) = both valid & cred!=0 & pairing legal, with both readys high in that cycle.
- Output: hdr_* registered. hdr_valid_o=1 exactly one cycle after fire, carrying both data words, sop0 as hdr_sop_o and eop0 as hdr_eop_o. Otherwise hdr_valid_o=0 and the data regs hold their last value.
- Credits:
  - cred−1 on fire, +1 on fifo_pop_i; both together leaves cred unchanged.
  - fifo_pop_i while cred==FIFO_DEPTH is ignored (saturate; never exceeds FIFO_DEPTH).
  - cred==0 blocks fire.
- FSM states IDLE, SEEK, RUN:
  - IDLE:
    - readys 0.
    - enable_i=1 → SEEK next cycle.
  - SEEK:
    - Each stream handled independently: a valid non-SOP beat is discarded (ready=1, no output, no error). A stream presenting a valid SOP stalls (ready=0).
    - When both present valid SOP and cred!=0: fire (readys 1) → RUN.
    - enable_i=0 in SEEK → IDLE (no discards that cycle).
  - RUN:
    - Legal pair: sop0=0, sop1=0, eop0==eop1. Fire when legal & both valid & cred!=0.
    - Fire with eop: frame_cnt+1, next state SEEK if enable_i=1 else IDLE.
    - Both valid and illegal (any sop, or eop mismatch): no transfer, sync_err_o=1 for one cycle, → SEEK. The offending beats are not consumed; SEEK handles them.
    - Only one stream valid: wait, readys 0; no error detection until both are valid.
    - enable_i deassert in RUN is ignored until EOP fires (the frame always completes).
- Readys are combinational from state, valids, sop, eop and cred; they never depend on their own sink's ready.
- Reset mid-operation: immediate return to reset values; in-flight merge-stage data is not tracked.

Decomposition:
- Package hdr_sched_pkg:
  - state enum {IDLE, SEEK, RUN};
  - localparams for default CW/FCW;
  - function legal_pair(sop0, sop1, eop0, eop1).
- Sub-module hdr_credit_counter: params DEPTH, CW; ports clk, reset, take_i, give_i, cred_o, avail_o. Holds the saturating up/down logic.

Test Plan:
- Aligned frames, FIFO_DEPTH=32, fifo_pop_i=1: both streams send 4 beats (0x10..0x13 and 0x20..0x23) with SOP on beat 0 and EOP on beat 3 → 4 hdr_valid beats, sop on the first, eop on the fourth, pairs (0x10,0x20)…(0x13,0x23), frame_cnt_o=1, sync_err_o never 1.
- Tail garbage: snk1 sends 2 non-SOP beats before its SOP, snk0 starts at SOP → the 2 beats are discarded, snk0 stalls until snk1's SOP, first output pair is the SOP pair, sync_err_o=0.
- Mid-frame SOP: snk1 asserts sop on beat 2 of a 4-beat frame → sync_err_o one-cycle pulse, no hdr_valid for that beat, snk0 tail discarded, pairing resumes at the next SOP pair.
- Credit limit, FIFO_DEPTH=4, fifo_pop_i=0: an 8-beat frame → exactly 4 hdr_valid, then both readys 0. A single fifo_pop_i pulse → exactly one more fire next cycle. Pop at cred=4 leaves cred at 4.
- Enable drop: enable_i→0 at beat 1 of 4 → frame completes through EOP, then IDLE with readys 0 and busy_o=0. Re-enable → SEEK.
- Reset at beat 2 of a frame → next cycle all outputs 0, cred=FIFO_DEPTH, frame_cnt_o=0, state IDLE.

Source files
------------

// File: rtl/hdr_sched_pkg.sv
// hdr_sched_pkg: shared state encoding, default widths and pairing rule for the HDR pair scheduler
package hdr_sched_pkg;

   typedef enum logic [1:0] {IDLE, SEEK, RUN} state_t;

   localparam int DEF_CW  = 6;
   localparam int DEF_FCW = 16;

   // Mid-frame beats pair only when neither starts a frame and both agree on frame end
   function automatic logic legal_pair(input logic sop0, input logic sop1, input logic eop0, input logic eop1);
      return !sop0 && !sop1 && (eop0 == eop1);
   endfunction

endpackage

// File: rtl/hdr_credit_counter.sv
// hdr_credit_counter: saturating credit tracker for the downstream output FIFO
module hdr_credit_counter #(
   parameter int DEPTH = 32,
   parameter int CW    = 6
) (
   input  logic          clk,
   input  logic          reset,
   input  logic          take_i,
   input  logic          give_i,
   output logic [CW-1:0] cred_o,
   output logic          avail_o
);

   localparam logic [CW-1:0] FULL = CW'(DEPTH);

   always_ff @(posedge clk or posedge reset)
      if (reset)
         cred_o <= FULL;
      else if (take_i && !give_i)
         cred_o <= cred_o - CW'(1);
      else if (give_i && !take_i && cred_o != FULL)
         cred_o <= cred_o + CW'(1);

   assign avail_o = cred_o != '0;

endmodule

// File: rtl/hdr_pair_scheduler.sv
// hdr_pair_scheduler: pairs long/short exposure beats on SOP and issues them to the
// fixed-latency HDR merge stage only when an output-FIFO credit is available
module hdr_pair_scheduler
   import hdr_sched_pkg::*;
#(
   parameter int DATA_WIDTH = 32,
   parameter int FIFO_DEPTH = 32,
   parameter int CW         = DEF_CW,
   parameter int FCW        = DEF_FCW
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  enable_i,
   input  logic                  snk0_valid_i,
   input  logic [DATA_WIDTH-1:0] snk0_data_i,
   input  logic                  snk0_sop_i,
   input  logic                  snk0_eop_i,
   output logic                  snk0_ready_o,
   input  logic                  snk1_valid_i,
   input  logic [DATA_WIDTH-1:0] snk1_data_i,
   input  logic                  snk1_sop_i,
   input  logic                  snk1_eop_i,
   output logic                  snk1_ready_o,
   input  logic                  fifo_pop_i,
   output logic                  hdr_valid_o,
   output logic                  hdr_sop_o,
   output logic                  hdr_eop_o,
   output logic [DATA_WIDTH-1:0] hdr_data0_o,
   output logic [DATA_WIDTH-1:0] hdr_data1_o,
   output logic                  sync_err_o,
   output logic [FCW-1:0]        frame_cnt_o,
   output logic                  busy_o
);

   state_t        state, state_n;
   logic          fire, err, done, avail, both;
   logic [CW-1:0] cred;

   hdr_credit_counter #(.DEPTH(FIFO_DEPTH), .CW(CW)) u_cred (
      .clk     (clk),
      .reset   (reset),
      .take_i  (fire),
      .give_i  (fifo_pop_i),
      .cred_o  (cred),
      .avail_o (avail)
   );

   assign both = snk0_valid_i && snk1_valid_i;

   always_comb begin
      state_n      = state;
      fire         = 1'b0;
      err          = 1'b0;
      done         = 1'b0;
      snk0_ready_o = 1'b0;
      snk1_ready_o = 1'b0;
      unique case (state)
         IDLE: state_n = enable_i ? SEEK : IDLE;
         SEEK: begin
            // Non-SOP beats are flushed; a stream already at SOP waits for its partner
            fire         = enable_i && both && snk0_sop_i && snk1_sop_i && avail;
            snk0_ready_o = fire || (enable_i && snk0_valid_i && !snk0_sop_i);
            snk1_ready_o = fire || (enable_i && snk1_valid_i && !snk1_sop_i);
            state_n      = !enable_i ? IDLE : fire ? RUN : SEEK;
         end
         RUN: begin
            fire         = both && legal_pair(snk0_sop_i, snk1_sop_i, snk0_eop_i, snk1_eop_i) && avail;
            err          = both && !legal_pair(snk0_sop_i, snk1_sop_i, snk0_eop_i, snk1_eop_i);
            done         = fire && snk0_eop_i;
            snk0_ready_o = fire;
            snk1_ready_o = fire;
            state_n      = err ? SEEK : done ? (enable_i ? SEEK : IDLE) : RUN;
         end
         default: state_n = IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge reset)
      if (reset) begin
         state       <= IDLE;
         hdr_valid_o <= 1'b0;
         hdr_sop_o   <= 1'b0;
         hdr_eop_o   <= 1'b0;
         hdr_data0_o <= '0;
         hdr_data1_o <= '0;
         sync_err_o  <= 1'b0;
         frame_cnt_o <= '0;
      end else begin
         state       <= state_n;
         hdr_valid_o <= fire;
         sync_err_o  <= err;
         if (fire) begin
            hdr_sop_o   <= snk0_sop_i;
            hdr_eop_o   <= snk0_eop_i;
            hdr_data0_o <= snk0_data_i;
            hdr_data1_o <= snk1_data_i;
         end
         if (done)
            frame_cnt_o <= frame_cnt_o + FCW'(1);
      end

   assign busy_o = state != IDLE;

   // Credits can never exceed the FIFO size
   assert property (@(posedge clk) disable iff (reset) cred <= CW'(FIFO_DEPTH));

endmodule
